regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of two, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, register 0 is a static zero register.
REQ-004 SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to read ports.
REQ-005 SHALL have port Clk  input  1  clock, all state updates on rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ReadRegister1 / ReadRegister2  input  AW  read addresses.
REQ-008 SHALL have port ReadData1 / ReadData2  output  WIDTH  asynchronous read data.
REQ-009 SHALL have port Ready1 / Ready2  output  1  addressed register has no pending producer.
REQ-010 SHALL have port WriteRegister  input  AW  write address.
REQ-011 SHALL have port WriteData  input  WIDTH  write data.
REQ-012 SHALL have port RegWrite  input  1  write enable, high = write.
REQ-013 SHALL have port ReserveRegister  input  AW  register to mark pending.
REQ-014 SHALL have port Reserve  input  1  reserve enable, high = mark pending.
REQ-015 SHALL have port PendingCount  output  AW+1  number of registers currently pending.

Function
REQ-016 SHALL hold DEPTH registers of WIDTH bits plus one pending bit per register.
REQ-017 SHALL write WriteData to WriteRegister on rising Clk when RegWrite=1 and Reset=0.
REQ-018 SHALL present ReadDataN combinationally from ReadRegisterN; zero read latency.
REQ-019 SHALL, with ZERO_REG=1, read register 0 as all zeros and ignore writes and reserves to it; Ready for register 0 always 1.
REQ-020 SHALL, with BYPASS=1, drive ReadDataN=WriteData and ReadyN=1 when RegWrite=1 and WriteRegister==ReadRegisterN (excluding zero register when ZERO_REG=1); with BYPASS=0, reads return the stored value until the next edge.
REQ-021 SHALL set pending[ReserveRegister] on rising Clk when Reserve=1.
REQ-022 SHALL clear pending[WriteRegister] on rising Clk when RegWrite=1.
REQ-023 SHALL, when Reserve and RegWrite target the same register in one cycle, perform the write and leave pending set (new producer wins).
REQ-024 SHALL treat Reserve on an already pending register as no change (no double count).
REQ-025 SHALL treat RegWrite to a non-pending register as a plain write; pending unchanged.
REQ-026 SHALL drive ReadyN = ~pending[ReadRegisterN], subject to REQ-019/REQ-020.
REQ-027 SHALL update PendingCount registered: +1, -1, or unchanged per edge from actual pending-bit transitions; never exceeds DEPTH (DEPTH-1 when ZERO_REG=1), never wraps below 0.
REQ-028 SHALL ignore Reserve and RegWrite in any cycle where Reset=1.

Reset
REQ-029 SHALL, on rising Clk with Reset=1, clear all registers to 0, clear all pending bits, set PendingCount=0.
REQ-030 SHALL, after Reset asserted mid-operation, drive ReadyN=1 and ReadDataN=0 for every address from the following cycle (bypass still applies once Reset=0).
REQ-031 SHALL have undefined contents only before the first reset edge; no asynchronous reset path.

Verification
REQ-032 SHALL cover: Reset; write 0xDEADBEEF to r5; read r5 on both ports next cycle -> ReadData1=ReadData2=0xDEADBEEF, Ready=1.
REQ-033 SHALL cover: write 0x12345678 to r0 (ZERO_REG=1) -> ReadData1 for r0 = 0, PendingCount=0.
REQ-034 SHALL cover: Reserve r7 -> Ready1=0 for r7, PendingCount=1; RegWrite r7=0xA5A5A5A5 -> same-cycle ReadData1=0xA5A5A5A5, Ready1=1 (BYPASS=1); next cycle PendingCount=0.
REQ-035 SHALL cover: Reserve r3 and RegWrite r3=0x1 same cycle -> r3 reads 0x1, Ready=0, PendingCount=1.
REQ-036 SHALL cover: Reserve r1..r31 consecutively, re-reserve r4 -> PendingCount=31; Reset -> all Ready=1, PendingCount=0, r1..r31 read 0.
REQ-037 SHALL cover: WIDTH=16, DEPTH=8, BYPASS=0; write r6=0xBEEF -> same-cycle read returns prior value 0, next cycle 0xBEEF.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits, asynchronous reads,
// optional hardwired zero register and optional same-cycle write forwarding.
module regfile_scoreboard #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [AW-1:0]    ReadRegister1,
    input  logic [AW-1:0]    ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             Ready1,
    output logic             Ready2,
    input  logic [AW-1:0]    WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             RegWrite,
    input  logic [AW-1:0]    ReserveRegister,
    input  logic             Reserve,
    output logic [AW:0]      PendingCount
);

    logic [WIDTH-1:0] w_word [DEPTH];
    logic             w_pend [DEPTH];
    logic [AW-1:0]    w_raddr [2];
    logic [WIDTH-1:0] w_rdata [2];
    logic             w_rready [2];
    logic             w_wr_req;
    logic             w_wr_valid;
    logic             w_rsv_valid;
    logic             w_set_inc;
    logic             w_clr_dec;
    logic [AW:0]      r_count;

    // Requests that target the hardwired zero register are dropped entirely.
    assign w_wr_req    = RegWrite & ~Reset;
    assign w_wr_valid  = w_wr_req & ~((ZERO_REG != 0) && (WriteRegister == '0));
    assign w_rsv_valid = Reserve & ~Reset & ~((ZERO_REG != 0) && (ReserveRegister == '0));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic [WIDTH-1:0] r_word;
            logic             r_pend;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_word <= '0;
                    r_pend <= 1'b0;
                end else begin
                    if (w_wr_valid && (WriteRegister == AW'(gi)))
                        r_word <= WriteData;
                    // A new reservation outranks the completing write to the same register.
                    if (w_rsv_valid && (ReserveRegister == AW'(gi)))
                        r_pend <= 1'b1;
                    else if (w_wr_valid && (WriteRegister == AW'(gi)))
                        r_pend <= 1'b0;
                end
            end

            assign w_word[gi] = r_word;
            assign w_pend[gi] = r_pend;
        end
    endgenerate

    assign w_raddr[0] = ReadRegister1;
    assign w_raddr[1] = ReadRegister2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic w_is_zero;
            logic w_hit;

            assign w_is_zero    = (ZERO_REG != 0) && (w_raddr[gi] == '0);
            assign w_hit        = (BYPASS != 0) && w_wr_req && (WriteRegister == w_raddr[gi]) && !w_is_zero;
            assign w_rdata[gi]  = w_is_zero ? '0 : (w_hit ? WriteData : w_word[w_raddr[gi]]);
            assign w_rready[gi] = w_is_zero | w_hit | ~w_pend[w_raddr[gi]];
        end
    endgenerate

    assign ReadData1 = w_rdata[0];
    assign ReadData2 = w_rdata[1];
    assign Ready1    = w_rready[0];
    assign Ready2    = w_rready[1];

    // Count follows real pending-bit transitions only, so it can never over- or underflow.
    assign w_set_inc = w_rsv_valid & ~w_pend[ReserveRegister];
    assign w_clr_dec = w_wr_valid & w_pend[WriteRegister]
                     & ~(w_rsv_valid & (ReserveRegister == WriteRegister));

    always_ff @(posedge Clk) begin
        if (Reset)
            r_count <= '0;
        else if (w_set_inc && !w_clr_dec)
            r_count <= r_count + 1'b1;
        else if (!w_set_inc && w_clr_dec)
            r_count <= r_count - 1'b1;
    end

    assign PendingCount = r_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default 32x32 bypassing instance and a 16x8 non-bypassing
// instance, checked against array-based reference models under directed and random stimulus.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    // Instance A: defaults (WIDTH=32, DEPTH=32, ZERO_REG=1, BYPASS=1)
    logic        a_rst, a_we, a_res;
    logic [4:0]  a_rr1, a_rr2, a_wr, a_resr;
    logic [31:0] a_wd, a_rd1, a_rd2;
    logic        a_rdy1, a_rdy2;
    logic [5:0]  a_cnt;

    // Instance B: WIDTH=16, DEPTH=8, ZERO_REG=1, BYPASS=0
    logic        b_rst, b_we, b_res;
    logic [2:0]  b_rr1, b_rr2, b_wr, b_resr;
    logic [15:0] b_wd, b_rd1, b_rd2;
    logic        b_rdy1, b_rdy2;
    logic [3:0]  b_cnt;

    regfile_scoreboard u_dut_a (
        .Clk(clk), .Reset(a_rst),
        .ReadRegister1(a_rr1), .ReadRegister2(a_rr2),
        .ReadData1(a_rd1), .ReadData2(a_rd2),
        .Ready1(a_rdy1), .Ready2(a_rdy2),
        .WriteRegister(a_wr), .WriteData(a_wd), .RegWrite(a_we),
        .ReserveRegister(a_resr), .Reserve(a_res),
        .PendingCount(a_cnt)
    );

    regfile_scoreboard #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1), .BYPASS(0)) u_dut_b (
        .Clk(clk), .Reset(b_rst),
        .ReadRegister1(b_rr1), .ReadRegister2(b_rr2),
        .ReadData1(b_rd1), .ReadData2(b_rd2),
        .Ready1(b_rdy1), .Ready2(b_rdy2),
        .WriteRegister(b_wr), .WriteData(b_wd), .RegWrite(b_we),
        .ReserveRegister(b_resr), .Reserve(b_res),
        .PendingCount(b_cnt)
    );

    // Reference state: architectural contents and pending flags
    logic [31:0] ma_mem  [32];
    bit          ma_pend [32];
    logic [15:0] mb_mem  [8];
    bit          mb_pend [8];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // {ready, data} an instance-A read port must show right now
    function automatic logic [32:0] a_expect(input logic [4:0] addr);
        if (addr == 5'd0)                         return {1'b1, 32'h0};
        if (a_we && !a_rst && a_wr == addr)       return {1'b1, a_wd};
        return {~ma_pend[addr], ma_mem[addr]};
    endfunction

    function automatic logic [16:0] b_expect(input logic [2:0] addr);
        if (addr == 3'd0) return {1'b1, 16'h0};
        return {~mb_pend[addr], mb_mem[addr]};
    endfunction

    task automatic check_reads(input string tag);
        logic [32:0] ea;
        logic [16:0] eb;
        #1;
        ea = a_expect(a_rr1);
        check_value({tag, ".a_rd1"},  a_rd1,        ea[31:0]);
        check_value({tag, ".a_rdy1"}, 32'(a_rdy1),  32'(ea[32]));
        ea = a_expect(a_rr2);
        check_value({tag, ".a_rd2"},  a_rd2,        ea[31:0]);
        check_value({tag, ".a_rdy2"}, 32'(a_rdy2),  32'(ea[32]));
        eb = b_expect(b_rr1);
        check_value({tag, ".b_rd1"},  32'(b_rd1),   32'(eb[15:0]));
        check_value({tag, ".b_rdy1"}, 32'(b_rdy1),  32'(eb[16]));
        eb = b_expect(b_rr2);
        check_value({tag, ".b_rd2"},  32'(b_rd2),   32'(eb[15:0]));
        check_value({tag, ".b_rdy2"}, 32'(b_rdy2),  32'(eb[16]));
    endtask

    // One clock: update the models from the applied inputs, then check pending counts.
    task automatic tick();
        int ca, cb;
        @(posedge clk);
        if (a_rst) begin
            foreach (ma_mem[i]) begin ma_mem[i] = '0; ma_pend[i] = 0; end
        end else begin
            if (a_we && a_wr != 0) begin ma_mem[a_wr] = a_wd; ma_pend[a_wr] = 0; end
            if (a_res && a_resr != 0) ma_pend[a_resr] = 1;
        end
        if (b_rst) begin
            foreach (mb_mem[i]) begin mb_mem[i] = '0; mb_pend[i] = 0; end
        end else begin
            if (b_we && b_wr != 0) begin mb_mem[b_wr] = b_wd; mb_pend[b_wr] = 0; end
            if (b_res && b_resr != 0) mb_pend[b_resr] = 1;
        end
        ca = 0;
        cb = 0;
        foreach (ma_pend[i]) ca += int'(ma_pend[i]);
        foreach (mb_pend[i]) cb += int'(mb_pend[i]);
        #1;
        check_value("a_cnt", 32'(a_cnt), 32'(ca));
        check_value("b_cnt", 32'(b_cnt), 32'(cb));
        n_txn++;
        $display("txn %0d: A rst=%0d we=%0d wr=%0d res=%0d resr=%0d cnt=%0d | B rst=%0d we=%0d wr=%0d res=%0d resr=%0d cnt=%0d",
                 n_txn, a_rst, a_we, a_wr, a_res, a_resr, a_cnt, b_rst, b_we, b_wr, b_res, b_resr, b_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        a_rst = 0; a_we = 0; a_res = 0;
        b_rst = 0; b_we = 0; b_res = 0;
    endtask

    initial begin
        idle();
        a_rr1 = 0; a_rr2 = 0; a_wr = 0; a_resr = 0; a_wd = 0;
        b_rr1 = 0; b_rr2 = 0; b_wr = 0; b_resr = 0; b_wd = 0;
        @(negedge clk);
        a_rst = 1; b_rst = 1;
        tick();
        idle();
        a_rr1 = 5; a_rr2 = 5;
        check_reads("reset");

        // Write then read on both ports next cycle
        a_we = 1; a_wr = 5; a_wd = 32'hDEADBEEF;
        tick();
        idle();
        check_reads("r5");
        check_value("r5_rd1", a_rd1, 32'hDEADBEEF);
        check_value("r5_rd2", a_rd2, 32'hDEADBEEF);

        // Zero register ignores writes
        a_we = 1; a_wr = 0; a_wd = 32'h12345678; a_rr1 = 0;
        check_reads("r0_same");
        tick();
        idle();
        check_reads("r0");
        check_value("r0_rd1", a_rd1, 32'h0);
        check_value("r0_cnt", 32'(a_cnt), 32'd0);

        // Reserve then complete with same-cycle forwarding
        a_res = 1; a_resr = 7;
        tick();
        idle();
        a_rr1 = 7;
        check_reads("r7_pend");
        check_value("r7_rdy_pend", 32'(a_rdy1), 32'd0);
        check_value("r7_cnt1", 32'(a_cnt), 32'd1);
        a_we = 1; a_wr = 7; a_wd = 32'hA5A5A5A5;
        check_reads("r7_byp");
        check_value("r7_byp_rd", a_rd1, 32'hA5A5A5A5);
        check_value("r7_byp_rdy", 32'(a_rdy1), 32'd1);
        tick();
        idle();
        check_value("r7_cnt0", 32'(a_cnt), 32'd0);

        // Reserve and write the same register together: new producer wins
        a_res = 1; a_resr = 3; a_we = 1; a_wr = 3; a_wd = 32'h1;
        tick();
        idle();
        a_rr1 = 3;
        check_reads("r3");
        check_value("r3_rd", a_rd1, 32'h1);
        check_value("r3_rdy", 32'(a_rdy1), 32'd0);
        check_value("r3_cnt", 32'(a_cnt), 32'd1);

        // Fill every reservable register, re-reserve one, then reset
        for (int i = 1; i < 32; i++) begin
            a_res = 1; a_resr = 5'(i);
            tick();
        end
        a_resr = 4;
        tick();
        idle();
        check_value("full_cnt", 32'(a_cnt), 32'd31);
        a_rst = 1;
        tick();
        idle();
        check_value("post_rst_cnt", 32'(a_cnt), 32'd0);
        for (int i = 0; i < 32; i++) begin
            a_rr1 = 5'(i); a_rr2 = 5'(31 - i);
            check_reads("post_rst");
            tick();
        end

        // No forwarding: same-cycle read shows the old value
        b_we = 1; b_wr = 6; b_wd = 16'hBEEF; b_rr1 = 6;
        check_reads("b_r6_same");
        check_value("b_r6_old", 32'(b_rd1), 32'h0);
        tick();
        idle();
        check_reads("b_r6");
        check_value("b_r6_new", 32'(b_rd1), 32'hBEEF);

        // Randomized traffic on both instances
        for (int t = 0; t < 800; t++) begin
            a_rst = ($urandom_range(0, 59) == 0);
            a_we  = $urandom_range(0, 1) == 1;
            a_res = $urandom_range(0, 1) == 1;
            a_wr  = 5'($urandom);
            a_resr = ($urandom_range(0, 3) == 0) ? a_wr : 5'($urandom);
            a_wd  = $urandom;
            a_rr1 = ($urandom_range(0, 3) == 0) ? a_wr : 5'($urandom);
            a_rr2 = 5'($urandom);
            b_rst = ($urandom_range(0, 59) == 0);
            b_we  = $urandom_range(0, 1) == 1;
            b_res = $urandom_range(0, 1) == 1;
            b_wr  = 3'($urandom);
            b_resr = ($urandom_range(0, 3) == 0) ? b_wr : 3'($urandom);
            b_wd  = 16'($urandom);
            b_rr1 = ($urandom_range(0, 3) == 0) ? b_wr : 3'($urandom);
            b_rr2 = 3'($urandom);
            check_reads("rand");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
